// File: rtl/count_refresh_sink.sv
// count_refresh_sink: BCD counter with one-digit-per-cycle carry engine,
// refresh latch and serial display shifter.
module count_refresh_sink #(
  parameter int DIGITS    = 6,
  parameter int SHIFT_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc_clk,
  input  logic [DIGITS-1:0]     inc_sel,
  input  logic                  ref_clk,
  output logic [4*DIGITS-1:0]   count_value,
  output logic [4*DIGITS-1:0]   display_value,
  output logic                  busy,
  output logic                  overflow,
  output logic                  ser_data,
  output logic                  ser_clk,
  output logic                  ser_latch
);
  localparam int W  = 4 * DIGITS;
  localparam int BW = $clog2(W);
  localparam int DW = $clog2(2 * SHIFT_DIV);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH
  } state_t;

  logic [W-1:0]      d_q, d_d;
  logic [W-1:0]      disp_q, disp_d;
  logic [DIGITS-1:0] p_q, p_d;
  logic [DIGITS-1:0] h_q, h_d;
  logic [DIGITS:0]   p_ext;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic              rp_q, rp_d;
  logic              found;
  state_t            state_q, state_d;
  logic [BW-1:0]     bit_q;
  logic [DW-1:0]     div_q;
  logic              start;
  logic              div_end;
  logic              last_bit;

  // Highest pending digit first, so a carry always lands on a clear bit.
  always_comb begin
    d_d   = d_q;
    h_d   = h_q;
    p_ext = {1'b0, p_q};
    found = 1'b0;
    if (p_q != '0) begin
      for (int i = DIGITS - 1; i >= 0; i--) begin
        if (p_q[i] && !found) begin
          found    = 1'b1;
          p_ext[i] = 1'b0;
          if (d_q[4*i +: 4] == 4'd9) begin
            d_d[4*i +: 4] = 4'd0;
            p_ext[i+1]    = 1'b1;
          end else begin
            d_d[4*i +: 4] = d_q[4*i +: 4] + 4'd1;
          end
        end
      end
    end else if (h_q != '0) begin
      p_ext = {1'b0, h_q};
      h_d   = '0;
    end
    ovf_d = ovf_q | p_ext[DIGITS];
    p_d   = p_ext[DIGITS-1:0];
    if (inc_clk) begin
      if (p_q == '0 && h_q == '0) begin
        p_d = inc_sel;
      end else begin
        h_d = h_d | inc_sel;
      end
    end
    busy_d = (p_d != '0) || (h_d != '0);
  end

  assign start  = (ref_clk || rp_q) && !busy_q && (state_q == S_IDLE);
  assign rp_d   = start ? 1'b0 : (ref_clk ? 1'b1 : rp_q);
  assign disp_d = start ? d_q : disp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      d_q     <= '0;
      p_q     <= '0;
      h_q     <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rp_q    <= 1'b0;
      disp_q  <= '0;
      state_q <= S_IDLE;
    end else begin
      d_q     <= d_d;
      p_q     <= p_d;
      h_q     <= h_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      rp_q    <= rp_d;
      disp_q  <= disp_d;
      state_q <= state_d;
    end
  end

  assign div_end  = div_q == DW'(2 * SHIFT_DIV - 1);
  assign last_bit = bit_q == '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (div_end && last_bit) state_d = S_LATCH;
      S_LATCH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || state_q != S_SHIFT) begin
      bit_q <= BW'(W - 1);
      div_q <= '0;
    end else if (div_end) begin
      bit_q <= bit_q - 1'b1;
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  always_comb begin
    ser_data  = 1'b0;
    ser_clk   = 1'b0;
    ser_latch = 1'b0;
    unique case (state_q)
      S_SHIFT: begin
        ser_data = disp_q[bit_q];
        ser_clk  = div_q >= DW'(SHIFT_DIV);
      end
      S_LATCH: ser_latch = 1'b1;
      default: ;
    endcase
  end

  assign count_value   = d_q;
  assign display_value = disp_q;
  assign busy          = busy_q;
  assign overflow      = ovf_q;
endmodule

// File: tb/tb_count_refresh_sink.sv
// Bench for count_refresh_sink: decimal-arithmetic model, random increments,
// serial stream capture and reset-abort checks.
module tb_count_refresh_sink;
  localparam int D   = 6;
  localparam int MOD = 1000000;

  logic         clk = 1'b0;
  logic         reset;
  logic         inc_clk;
  logic [D-1:0] inc_sel;
  logic         ref_clk;
  logic [23:0]  count_value;
  logic [23:0]  display_value;
  logic         busy;
  logic         overflow;
  logic         ser_data;
  logic         ser_clk;
  logic         ser_latch;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   m_val;
  logic m_ovf;

  count_refresh_sink #(.DIGITS(D), .SHIFT_DIV(4)) dut (
    .clk(clk), .reset(reset), .inc_clk(inc_clk), .inc_sel(inc_sel),
    .ref_clk(ref_clk), .count_value(count_value),
    .display_value(display_value), .busy(busy), .overflow(overflow),
    .ser_data(ser_data), .ser_clk(ser_clk), .ser_latch(ser_latch)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int pow10(int i);
    int r = 1;
    for (int k = 0; k < i; k++) r *= 10;
    return r;
  endfunction

  function automatic logic [23:0] to_bcd(int v);
    logic [23:0] r;
    int t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int sel_val(logic [D-1:0] s);
    int r = 0;
    for (int i = 0; i < D; i++) if (s[i]) r += pow10(i);
    return r;
  endfunction

  // One cycle per single-digit increment event: selected digits plus
  // carries into a digit that exists.
  function automatic int work_cycles(int v, logic [D-1:0] s);
    int c = 0;
    int n = 0;
    int dig, add;
    for (int i = 0; i < D; i++) begin
      dig = (v / pow10(i)) % 10;
      add = int'(s[i]) + c;
      n += add;
      c = (dig + add > 9) ? 1 : 0;
    end
    return n;
  endfunction

  function automatic void model_add(int a);
    m_val += a;
    if (m_val >= MOD) begin
      m_val -= MOD;
      m_ovf = 1'b1;
    end
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_val = 0;
    m_ovf = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    chk("idle_timeout", n < 100, 1);
  endtask

  task automatic do_inc(input logic [D-1:0] s, input string tag);
    int exp_c;
    int n = 0;
    exp_c = work_cycles(m_val, s);
    inc_clk = 1'b1;
    inc_sel = s;
    tick();
    inc_clk = 1'b0;
    inc_sel = '0;
    while (busy && n < 50) begin
      n++;
      tick();
    end
    model_add(sel_val(s));
    chk({tag, "_busy"}, n, exp_c);
    chk({tag, "_count"}, count_value, to_bcd(m_val));
    chk({tag, "_ovf"}, overflow, m_ovf);
  endtask

  task automatic capture(output logic [23:0] word, output int cyc,
                         output int latches, output int rises);
    logic prev;
    prev = 1'b0;
    word = '0;
    cyc = 0;
    latches = 0;
    rises = 0;
    for (int n = 1; n <= 600; n++) begin
      if (ser_clk && !prev) begin
        word = {word[22:0], ser_data};
        rises++;
      end
      prev = ser_clk;
      if (ser_latch) begin
        latches++;
        if (cyc == 0) cyc = n;
      end
      if (latches > 0 && n > cyc + 5) break;
      tick();
    end
  endtask

  task automatic do_refresh(input string tag);
    logic [23:0] w;
    int cyc, lat, rs;
    ref_clk = 1'b1;
    tick();
    ref_clk = 1'b0;
    chk({tag, "_disp"}, display_value, to_bcd(m_val));
    capture(w, cyc, lat, rs);
    chk({tag, "_stream"}, w, to_bcd(m_val));
    chk({tag, "_cycles"}, cyc, 193);
    chk({tag, "_latches"}, lat, 1);
    chk({tag, "_bits"}, rs, 24);
  endtask

  initial begin
    logic [23:0] w;
    logic [23:0] pre;
    int cyc, lat, rs, n;
    reset = 1'b0;
    inc_clk = 1'b0;
    inc_sel = '0;
    ref_clk = 1'b0;
    do_reset();
    chk("rst_count", count_value, 24'h0);
    chk("rst_disp", display_value, 24'h0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ser", {ser_data, ser_clk, ser_latch}, 3'b000);

    do_inc(6'b000001, "inc1");
    for (int i = 0; i < 8; i++) do_inc(6'b000001, "to9");
    do_inc(6'b000001, "carry10");

    do_reset();
    for (int i = 0; i < 9; i++) do_inc(6'b111111, "fill");
    do_inc(6'b111111, "wrap");
    chk("wrap_val", count_value, 24'h111110);

    do_reset();
    do_inc(6'b111111, "b1");
    do_inc(6'b011111, "b2");
    do_inc(6'b001111, "b3");
    do_inc(6'b000111, "b4");
    do_inc(6'b000011, "b5");
    do_inc(6'b000001, "b6");
    chk("val123456", count_value, 24'h123456);
    do_refresh("ref123456");

    // Refresh requested while busy, with a second increment held.
    pre = display_value;
    inc_clk = 1'b1;
    inc_sel = 6'b111111;
    tick();
    inc_clk = 1'b0;
    tick();
    inc_clk = 1'b1;
    inc_sel = 6'b000001;
    tick();
    inc_clk = 1'b0;
    inc_sel = '0;
    ref_clk = 1'b1;
    tick();
    ref_clk = 1'b0;
    chk("defer_busy", busy, 1);
    chk("defer_disp_old", display_value, pre);
    model_add(111112);
    capture(w, cyc, lat, rs);
    chk("defer_disp", display_value, to_bcd(m_val));
    chk("defer_stream", w, to_bcd(m_val));
    chk("defer_latches", lat, 1);
    chk("defer_count", count_value, to_bcd(m_val));

    // Same-edge increment and refresh latches the old value.
    pre = to_bcd(m_val);
    inc_clk = 1'b1;
    inc_sel = 6'b000101;
    ref_clk = 1'b1;
    tick();
    inc_clk = 1'b0;
    inc_sel = '0;
    ref_clk = 1'b0;
    chk("same_disp", display_value, pre);
    capture(w, cyc, lat, rs);
    chk("same_stream", w, pre);
    chk("same_cycles", cyc, 193);
    model_add(101);
    wait_idle();
    chk("same_count", count_value, to_bcd(m_val));

    for (int it = 0; it < 32; it++) begin
      do_inc(6'($urandom_range(0, 63)), "rnd");
      if (it % 8 == 7) do_refresh("rnd_ref");
    end

    // Reset while shifting aborts without a latch pulse.
    ref_clk = 1'b1;
    tick();
    ref_clk = 1'b0;
    rs = 0;
    n = 0;
    w[0] = 1'b0;
    while (rs < 10 && n < 400) begin
      if (ser_clk && !w[0]) rs++;
      w[0] = ser_clk;
      n++;
      tick();
    end
    chk("mid_reach", rs, 10);
    reset = 1'b1;
    tick();
    chk("mid_ser", {ser_data, ser_clk, ser_latch}, 3'b000);
    chk("mid_disp", display_value, 24'h0);
    chk("mid_count", count_value, 24'h0);
    chk("mid_ovf", overflow, 0);
    reset = 1'b0;
    m_val = 0;
    m_ovf = 1'b0;
    lat = 0;
    for (int i = 0; i < 300; i++) begin
      if (ser_latch || ser_clk) lat++;
      tick();
    end
    chk("mid_no_latch", lat, 0);
    do_inc(6'b100001, "post");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/count_refresh_sink.md
Name: count_refresh_sink

Overview:
- Receiving end of the input_trigger pulse interface: consumes the one-cycle `inc_clk` pulse (with a per-digit select vector) and the delayed one-cycle `ref_clk` pulse.
- Holds a DIGITS-wide BCD counter and resolves carries one digit per cycle, so every carry settles inside the trigger block's 16-cycle calculation window.
- On refresh, it latches the count and serially shifts it to an external display shift-register chain.

Parameters:
- DIGITS, 6, number of BCD digits (4 bits each).
- SHIFT_DIV, 4, system clocks per `ser_clk` phase (low or high); must be ≥1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- inc_clk  input  1  one-cycle increment strobe.
- inc_sel  input  DIGITS  digits to increment by one; sampled only when `inc_clk`=1.
- ref_clk  input  1  one-cycle refresh strobe.
- count_value  output  4*DIGITS  live BCD count; digit i is at [4i+3:4i].
- display_value  output  4*DIGITS  count latched at the last refresh.
- busy  output  1  carry engine has pending work.
- overflow  output  1  sticky; set when the top digit wraps 9→0.
- ser_data  output  1  serial display data, MSB first.
- ser_clk  output  1  serial display clock; data is valid on its rising edge.
- ser_latch  output  1  one-cycle strobe after the last bit.

Behaviour:
- **Reset** (sync, on a rising clk with reset=1): all digits, `display_value`, pending/hold/ref_pend registers, `overflow`, `ser_*` and `busy` go to 0; shifter goes to IDLE. Reset mid-carry or mid-shift aborts immediately, and no `ser_latch` is emitted.
- **Carry engine** (pending vector P, hold register H):
  - `inc_clk`=1 with P==0 and H==0: P←`inc_sel` at that edge; work starts the next cycle.
  - `inc_clk`=1 otherwise: H←H|`inc_sel`. Duplicate increments to an already-held digit are merged (documented loss).
  - Each cycle with P≠0, take k = highest set index of P:
    - d[k]==9: d[k]←0, clear P[k]; set P[k+1] if k<DIGITS-1, else set `overflow`.
    - otherwise: d[k]←d[k]+1, clear P[k].
  - Highest-first order guarantees P[k+1]==0 when a carry is set, so carries never collide.
  - When P becomes 0 and H≠0: P←H, H←0 on the next edge.
  - `busy` = (P≠0)|(H≠0), registered.
  - A single `inc_clk` completes in ≤ 2*DIGITS-1 cycles (11 for DIGITS=6).
  - `inc_sel`=0 with `inc_clk`=1 is a no-op.
  - Digits never hold values >9.
- **Refresh**:
  - `ref_clk`=1, or ref_pend set, while `busy`=0 and the shifter is IDLE: `display_value`←`count_value` at that edge; shifter starts the next cycle; ref_pend cleared.
  - `ref_clk` while `busy`=1 or the shifter is active: ref_pend←1 (one deep; extra requests merge). Serviced at the first edge where both conditions are clear.
  - Simultaneous `inc_clk` and `ref_clk` at the same edge: refresh latches the pre-increment value.
- **Shifter FSM**: IDLE → SHIFT → LATCH → IDLE.
  - SHIFT sends 4*DIGITS bits of the latched value, bit 4*DIGITS-1 first.
  - Per bit: `ser_data`=bit with `ser_clk`=0 for SHIFT_DIV cycles, then `ser_clk`=1 for SHIFT_DIV cycles.
  - LATCH: `ser_clk`=0, `ser_latch`=1 for exactly one cycle.
  - Total active cycles = 8*DIGITS*SHIFT_DIV+1 (193 at defaults).
  - `ser_data` and `ser_clk` are 0 in IDLE.
- Counter wrap: maximum value (all 9s) +1 at digit 0 → all 0s and `overflow`=1. `overflow` clears only on reset.

Test Plan:
- Reset, then `inc_clk` with `inc_sel`=6'b000001 → `count_value`=24'h000001 after 1 work cycle; `busy` high exactly 1 cycle.
- Count 24'h000009, `inc_sel`=000001 → 24'h000010 after 2 work cycles; `overflow`=0.
- Count 24'h999999, `inc_sel`=111111 → 24'h111110, `overflow`=1, `busy` high 11 cycles.
- Count 24'h123456, `ref_clk` pulse → `display_value`=24'h123456; serial stream 0001 0010 0011 0100 0101 0110 MSB first; `ser_latch` 1 cycle; 193 active cycles.
- `inc_clk` (`inc_sel`=000001) then `ref_clk` 3 cycles later while the carry engine is still busy → refresh deferred, then latches the incremented value; second `inc_clk` during busy → held and applied afterwards.
- Assert reset mid-shift (bit 10) → `ser_*`=0 the next cycle, no `ser_latch`, `display_value`=0.
